// File: rtl/draw_arbiter.sv
// Round-robin arbiter that shares one line engine among three draw requesters.
// It range-checks each command, waits out any stale finish level, and aborts runs that exceed TIMEOUT.
//   state    | meaning
//   IDLE     | no command; grant the next requester in round-robin order
//   CHECK    | ack visible; screen the latched endpoints against 640x480
//   ISSUE    | eng_start pulse; timeout counter cleared
//   WAIT_CLR | wait for the previous command's finish level to drop
//   RUN      | pixels forwarded with owner tag until the engine finishes
//   FIN      | done pulse
module draw_arbiter #(
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [29:0] rq_x1,
    input  logic [29:0] rq_x2,
    input  logic [26:0] rq_y1,
    input  logic [26:0] rq_y2,
    output logic [2:0]  ack,
    output logic [2:0]  done,
    output logic [2:0]  err,
    output logic        eng_start,
    output logic [9:0]  eng_x1,
    output logic [9:0]  eng_x2,
    output logic [8:0]  eng_y1,
    output logic [8:0]  eng_y2,
    input  logic        eng_finish,
    input  logic [9:0]  eng_px,
    input  logic [8:0]  eng_py,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_valid,
    output logic [1:0]  pix_owner,
    output logic        busy
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_CLR, RUN, FIN} state_t;

    state_t        state;
    logic [1:0]    rr;
    logic [1:0]    owner;
    logic [1:0]    gnt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [9:0]    sel_x1, sel_x2;
    logic [8:0]    sel_y1, sel_y2;
    logic          out_of_range;

    assign cnt_inc = cnt + CW'(1);
    assign out_of_range = (eng_x1 > 10'd639) || (eng_x2 > 10'd639) ||
                          (eng_y1 > 9'd479)  || (eng_y2 > 9'd479);

    // First requesting index at or above rr, wrapping; only used when req is non-zero.
    always_comb begin
        gnt = 2'd0;
        case (rr)
            2'd1:    gnt = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd2:    gnt = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: gnt = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        sel_x1 = rq_x1[9:0];
        sel_x2 = rq_x2[9:0];
        sel_y1 = rq_y1[8:0];
        sel_y2 = rq_y2[8:0];
        case (gnt)
            2'd1: begin
                sel_x1 = rq_x1[19:10];
                sel_x2 = rq_x2[19:10];
                sel_y1 = rq_y1[17:9];
                sel_y2 = rq_y2[17:9];
            end
            2'd2: begin
                sel_x1 = rq_x1[29:20];
                sel_x2 = rq_x2[29:20];
                sel_y1 = rq_y1[26:18];
                sel_y2 = rq_y2[26:18];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= 2'd0;
            owner     <= 2'd0;
            cnt       <= '0;
            ack       <= 3'b000;
            done      <= 3'b000;
            err       <= 3'b000;
            eng_start <= 1'b0;
            eng_x1    <= 10'd0;
            eng_x2    <= 10'd0;
            eng_y1    <= 9'd0;
            eng_y2    <= 9'd0;
        end else begin
            ack       <= 3'b000;
            done      <= 3'b000;
            err       <= 3'b000;
            eng_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner  <= gnt;
                        rr     <= (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
                        eng_x1 <= sel_x1;
                        eng_x2 <= sel_x2;
                        eng_y1 <= sel_y1;
                        eng_y2 <= sel_y2;
                        ack    <= 3'b001 << gnt;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (out_of_range) begin
                        err   <= 3'b001 << owner;
                        state <= IDLE;
                    end else begin
                        eng_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_CLR;
                end
                WAIT_CLR, RUN: begin
                    // The timeout wins over a finish seen in the same cycle.
                    if (cnt_inc == LIMIT) begin
                        err   <= 3'b001 << owner;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        if (state == WAIT_CLR && !eng_finish) begin
                            state <= RUN;
                        end else if (state == RUN && eng_finish) begin
                            done  <= 3'b001 << owner;
                            state <= FIN;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign pix_valid = (state == RUN) && !eng_finish;
    assign pix_x     = pix_valid ? eng_px : 10'd0;
    assign pix_y     = pix_valid ? eng_py : 9'd0;
    assign pix_owner = (state == RUN) ? owner : 2'd0;
endmodule

// File: tb/tb_draw_arbiter.sv
// Randomized bench for draw_arbiter: round-robin grant model plus per-command timeline
// predicted from the stale-finish delay, engine latency and timeout limit.
module tb_draw_arbiter;
    localparam int TMO = 16;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [29:0] rq_x1, rq_x2;
    logic [26:0] rq_y1, rq_y2;
    logic [2:0]  ack, done, err;
    logic        eng_start;
    logic [9:0]  eng_x1, eng_x2;
    logic [8:0]  eng_y1, eng_y2;
    logic        eng_finish;
    logic [9:0]  eng_px;
    logic [8:0]  eng_py;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_valid;
    logic [1:0]  pix_owner;
    logic        busy;

    draw_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req),
        .rq_x1(rq_x1), .rq_x2(rq_x2), .rq_y1(rq_y1), .rq_y2(rq_y2),
        .ack(ack), .done(done), .err(err), .eng_start(eng_start),
        .eng_x1(eng_x1), .eng_x2(eng_x2), .eng_y1(eng_y1), .eng_y2(eng_y2),
        .eng_finish(eng_finish), .eng_px(eng_px), .eng_py(eng_py),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_owner(pix_owner),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rr_m   = 0;

    logic [2:0]  snap_req;
    logic [29:0] snap_x1, snap_x2;
    logic [26:0] snap_y1, snap_y2;
    logic [9:0]  lx1, lx2;
    logic [8:0]  ly1, ly2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs seen by the DUT at this edge are snapshotted before the bench changes them.
    task automatic tick();
        @(posedge clk);
        snap_req = req;
        snap_x1  = rq_x1;
        snap_x2  = rq_x2;
        snap_y1  = rq_y1;
        snap_y2  = rq_y2;
        #1;
    endtask

    function automatic logic [9:0] rand_x(input bit ok_only);
        int r;
        r = ok_only ? 10 : int'($urandom_range(0, 19));
        case (r)
            0:       return 10'($urandom_range(640, 1023));
            1:       return 10'd639;
            2:       return 10'd640;
            3:       return 10'd0;
            default: return 10'($urandom_range(0, 639));
        endcase
    endfunction

    function automatic logic [8:0] rand_y(input bit ok_only);
        int r;
        r = ok_only ? 10 : int'($urandom_range(0, 19));
        case (r)
            0:       return 9'($urandom_range(480, 511));
            1:       return 9'd479;
            2:       return 9'd480;
            3:       return 9'd0;
            default: return 9'($urandom_range(0, 479));
        endcase
    endfunction

    task automatic gen_buses(input bit ok_only);
        for (int i = 0; i < 3; i++) begin
            rq_x1[10*i +: 10] = rand_x(ok_only);
            rq_x2[10*i +: 10] = rand_x(ok_only);
            rq_y1[9*i +: 9]   = rand_y(ok_only);
            rq_y2[9*i +: 9]   = ($urandom_range(0, 3) == 0) ? rq_y1[9*i +: 9] : rand_y(ok_only);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check_eq({tag, "_ctl"}, 32'({ack, done, err, eng_start, pix_valid, pix_owner, busy}), 32'd0);
        check_eq({tag, "_eng1"}, 32'({eng_x1, eng_y1}), 32'd0);
        check_eq({tag, "_eng2"}, 32'({eng_x2, eng_y2}), 32'd0);
        check_eq({tag, "_pix"}, 32'({pix_x, pix_y}), 32'd0);
    endtask

    task automatic wait_ack(output int g);
        bit got;
        int stray;
        int c;
        got   = 1'b0;
        stray = 0;
        for (int w = 0; w < 6; w++) begin
            tick();
            gen_buses(1'b0);
            @(negedge clk);
            if (ack != 3'b000) begin
                got = 1'b1;
                break;
            end
            if (done != 3'b000 || err != 3'b000) stray++;
        end
        check_eq("ack_seen", 32'(got), 32'd1);
        check_eq("stray_pulse", 32'(stray), 32'd0);
        g = 0;
        for (int i = 2; i >= 0; i--) begin
            c = (rr_m + i) % 3;
            if (snap_req[c]) g = c;
        end
        rr_m = (g + 1) % 3;
        lx1 = snap_x1[10*g +: 10];
        lx2 = snap_x2[10*g +: 10];
        ly1 = snap_y1[9*g +: 9];
        ly2 = snap_y2[9*g +: 9];
        check_eq("ack", 32'(ack), 32'(3'b001 << g));
        check_eq("latch_x", 32'({eng_x1, eng_x2}), 32'({lx1, lx2}));
        check_eq("latch_y", 32'({eng_y1, eng_y2}), 32'({ly1, ly2}));
    endtask

    // s: cycles of stale finish after start; L: engine cycles until finish rises (100 = never).
    task automatic finish_cmd(input int g, input logic [2:0] hold);
        int s, L, occupied, exp_k, end_k, pbad, sbad;
        bit valid, exp_v;
        logic [2:0] oh;
        logic [5:0] exp_end, end_v;
        s     = int'($urandom_range(0, 3));
        L     = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(1, 14));
        valid = (lx1 <= 10'd639) && (lx2 <= 10'd639) && (ly1 <= 9'd479) && (ly2 <= 9'd479);
        oh    = 3'b001 << g;
        req   = hold;
        tick();
        gen_buses(1'b0);
        eng_finish = (s > 0);
        @(negedge clk);
        check_eq("start_or_reject", 32'({eng_start, err, done}),
                 valid ? 32'({1'b1, 3'b000, 3'b000}) : 32'({1'b0, oh, 3'b000}));
        if (!valid) return;
        occupied = s + 1 + L;
        exp_k    = (occupied < TMO) ? occupied + 1 : TMO + 1;
        exp_end  = (occupied < TMO) ? {oh, 3'b000} : {3'b000, oh};
        end_k = 0;
        end_v = 6'd0;
        pbad  = 0;
        sbad  = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            gen_buses(1'b0);
            eng_finish = (k <= s) || (k > s + L);
            eng_px     = 10'($urandom);
            eng_py     = 9'($urandom);
            @(negedge clk);
            exp_v = (k >= s + 2) && (k <= s + L) && (k <= TMO);
            if (pix_valid !== exp_v) pbad++;
            else if (exp_v && (pix_x !== eng_px || pix_y !== eng_py || pix_owner !== 2'(g))) pbad++;
            else if (!exp_v && (pix_x !== 10'd0 || pix_y !== 9'd0)) pbad++;
            if (eng_start || ack != 3'b000 || eng_x1 !== lx1 || eng_x2 !== lx2 ||
                eng_y1 !== ly1 || eng_y2 !== ly2) sbad++;
            if (done != 3'b000 || err != 3'b000) begin
                end_k = k;
                end_v = {done, err};
                break;
            end
        end
        check_eq("pix_stream", 32'(pbad), 32'd0);
        check_eq("cmd_stable", 32'(sbad), 32'd0);
        check_eq("end_cycle", 32'(end_k), 32'(exp_k));
        check_eq("end_pulse", 32'(end_v), 32'(exp_end));
    endtask

    initial begin
        int g;
        logic [2:0] hold;
        reset = 1'b1;
        req = 3'b000;
        rq_x1 = '0; rq_x2 = '0; rq_y1 = '0; rq_y2 = '0;
        eng_finish = 1'b0;
        eng_px = '0;
        eng_py = '0;
        repeat (3) tick();
        @(negedge clk);
        check_idle_outs("reset");

        // Request already pending while reset is held: no grant before one cycle after release.
        req = 3'b111;
        gen_buses(1'b0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("no_early_grant", 32'(ack), 32'd0);

        for (int t = 0; t < 6; t++) begin
            wait_ack(g);
            finish_cmd(g, 3'b111);
        end

        for (int n = 0; n < 60; n++) begin
            if (req == 3'b000) req = 3'($urandom_range(1, 7));
            wait_ack(g);
            hold = (n == 59 || $urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            finish_cmd(g, hold);
        end

        // Reset in the middle of a run: silent abort and pointer back to requester 0.
        req = 3'b010;
        gen_buses(1'b1);
        wait_ack(g);
        req = 3'b000;
        eng_finish = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        req = 3'b111;
        @(negedge clk);
        check_eq("run_before_reset", 32'({pix_valid, busy}), 32'd3);
        tick();
        reset = 1'b0;
        rr_m = 0;
        @(negedge clk);
        check_idle_outs("midrun_reset");
        wait_ack(g);
        finish_cmd(g, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
